// File: rtl/insn_dispatch.sv
// Decode/dispatch stage: turns one AArch64 instruction word per cycle into a
// registered ALU micro-op bundle for the rename/read stage.
module insn_dispatch #(
  parameter int GPR_IDX_SIZE   = 5,
  parameter int IMMEDIATE_SIZE = 12
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_stall,
  input  logic [31:0]               in_fetch_insnbits,
  input  logic                      in_fetch_done,
  output logic                      out_reg_done,
  output logic                      out_reg_set_nzcv,
  output logic                      out_reg_instr_uses_nzcv,
  output logic                      out_reg_use_imm,
  output logic [IMMEDIATE_SIZE-1:0] out_reg_imm,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src1,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src2,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_dst,
  output logic [1:0]                out_reg_fu_id,
  output logic [3:0]                out_reg_fu_op,
  output logic [3:0]                out_reg_cond_codes
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_CSEL  = 4'd2;
  localparam logic [3:0] OP_CSINC = 4'd3;
  localparam logic [3:0] OP_CSINV = 4'd4;
  localparam logic [3:0] OP_CSNEG = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_ORR   = 4'd7;
  localparam logic [3:0] OP_EOR   = 4'd8;
  localparam logic [1:0] FU_ALU   = 2'b00;

  logic [10:0] opc_s;
  logic [1:0]  op2_s;
  logic [4:0]  rd_s;
  logic [4:0]  rn_s;
  logic [4:0]  rm_s;
  logic [11:0] imm12_s;
  logic [3:0]  cond_s;

  logic        dec_valid_s;
  logic        dec_set_nzcv_s;
  logic        dec_uses_nzcv_s;
  logic        dec_use_imm_s;
  logic [3:0]  dec_op_s;

  assign opc_s   = in_fetch_insnbits[31:21];
  assign op2_s   = in_fetch_insnbits[11:10];
  assign rd_s    = in_fetch_insnbits[4:0];
  assign rn_s    = in_fetch_insnbits[9:5];
  assign rm_s    = in_fetch_insnbits[20:16];
  assign imm12_s = in_fetch_insnbits[21:10];
  assign cond_s  = in_fetch_insnbits[15:12];

  // Opcode classification; bit 21 is part of imm12 for the immediate forms.
  always_comb begin
    dec_valid_s     = 1'b1;
    dec_set_nzcv_s  = 1'b0;
    dec_uses_nzcv_s = 1'b0;
    dec_use_imm_s   = 1'b0;
    dec_op_s        = OP_ADD;
    casez (opc_s)
      11'b1001000100?: begin dec_op_s = OP_ADD; dec_use_imm_s = 1'b1; end
      11'b1011000100?: begin dec_op_s = OP_ADD; dec_use_imm_s = 1'b1; dec_set_nzcv_s = 1'b1; end
      11'b1101000100?: begin dec_op_s = OP_SUB; dec_use_imm_s = 1'b1; end
      11'b1111000100?: begin dec_op_s = OP_SUB; dec_use_imm_s = 1'b1; dec_set_nzcv_s = 1'b1; end
      11'b10001011000: dec_op_s = OP_ADD;
      11'b10101011000: begin dec_op_s = OP_ADD; dec_set_nzcv_s = 1'b1; end
      11'b11001011000: dec_op_s = OP_SUB;
      11'b11101011000: begin dec_op_s = OP_SUB; dec_set_nzcv_s = 1'b1; end
      11'b10001010000: dec_op_s = OP_AND;
      11'b10101010000: dec_op_s = OP_ORR;
      11'b11001010000: dec_op_s = OP_EOR;
      11'b11101010000: begin dec_op_s = OP_AND; dec_set_nzcv_s = 1'b1; end
      11'b10011010100: begin
        dec_uses_nzcv_s = 1'b1;
        case (op2_s)
          2'b00:   dec_op_s = OP_CSEL;
          2'b01:   dec_op_s = OP_CSINC;
          default: dec_valid_s = 1'b0;
        endcase
      end
      11'b11011010100: begin
        dec_uses_nzcv_s = 1'b1;
        case (op2_s)
          2'b00:   dec_op_s = OP_CSINV;
          2'b01:   dec_op_s = OP_CSNEG;
          default: dec_valid_s = 1'b0;
        endcase
      end
      default: dec_valid_s = 1'b0;
    endcase
  end

  // Output bundle register: hold on stall, clear on bubble or unrecognised word.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_reg_done            <= 1'b0;
      out_reg_set_nzcv        <= 1'b0;
      out_reg_instr_uses_nzcv <= 1'b0;
      out_reg_use_imm         <= 1'b0;
      out_reg_imm             <= '0;
      out_reg_src1            <= '0;
      out_reg_src2            <= '0;
      out_reg_dst             <= '0;
      out_reg_fu_id           <= 2'b00;
      out_reg_fu_op           <= 4'd0;
      out_reg_cond_codes      <= 4'd0;
    end else if (!in_stall) begin
      if (in_fetch_done && dec_valid_s) begin
        out_reg_done            <= 1'b1;
        out_reg_set_nzcv        <= dec_set_nzcv_s;
        out_reg_instr_uses_nzcv <= dec_uses_nzcv_s;
        out_reg_use_imm         <= dec_use_imm_s;
        out_reg_imm             <= dec_use_imm_s ? IMMEDIATE_SIZE'(imm12_s) : '0;
        out_reg_src1            <= GPR_IDX_SIZE'(rn_s);
        out_reg_src2            <= dec_use_imm_s ? '0 : GPR_IDX_SIZE'(rm_s);
        out_reg_dst             <= GPR_IDX_SIZE'(rd_s);
        out_reg_fu_id           <= FU_ALU;
        out_reg_fu_op           <= dec_op_s;
        out_reg_cond_codes      <= dec_uses_nzcv_s ? cond_s : 4'd0;
      end else begin
        out_reg_done            <= 1'b0;
        out_reg_set_nzcv        <= 1'b0;
        out_reg_instr_uses_nzcv <= 1'b0;
        out_reg_use_imm         <= 1'b0;
        out_reg_imm             <= '0;
        out_reg_src1            <= '0;
        out_reg_src2            <= '0;
        out_reg_dst             <= '0;
        out_reg_fu_id           <= 2'b00;
        out_reg_fu_op           <= 4'd0;
        out_reg_cond_codes      <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_insn_dispatch.sv
// Self-checking bench for insn_dispatch: directed cases plus randomized
// instruction streams compared against a table-driven decode model.
module tb_insn_dispatch;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_stall;
  logic [31:0] in_fetch_insnbits;
  logic        in_fetch_done;
  logic        out_reg_done;
  logic        out_reg_set_nzcv;
  logic        out_reg_instr_uses_nzcv;
  logic        out_reg_use_imm;
  logic [11:0] out_reg_imm;
  logic [4:0]  out_reg_src1;
  logic [4:0]  out_reg_src2;
  logic [4:0]  out_reg_dst;
  logic [1:0]  out_reg_fu_id;
  logic [3:0]  out_reg_fu_op;
  logic [3:0]  out_reg_cond_codes;

  insn_dispatch dut (
    .in_clk                  (in_clk),
    .in_rst                  (in_rst),
    .in_stall                (in_stall),
    .in_fetch_insnbits       (in_fetch_insnbits),
    .in_fetch_done           (in_fetch_done),
    .out_reg_done            (out_reg_done),
    .out_reg_set_nzcv        (out_reg_set_nzcv),
    .out_reg_instr_uses_nzcv (out_reg_instr_uses_nzcv),
    .out_reg_use_imm         (out_reg_use_imm),
    .out_reg_imm             (out_reg_imm),
    .out_reg_src1            (out_reg_src1),
    .out_reg_src2            (out_reg_src2),
    .out_reg_dst             (out_reg_dst),
    .out_reg_fu_id           (out_reg_fu_id),
    .out_reg_fu_op           (out_reg_fu_op),
    .out_reg_cond_codes      (out_reg_cond_codes)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] obs;
  logic [63:0] exp_bundle;
  assign obs = {23'd0, out_reg_done, out_reg_set_nzcv, out_reg_instr_uses_nzcv,
                out_reg_use_imm, out_reg_imm, out_reg_src1, out_reg_src2,
                out_reg_dst, out_reg_fu_id, out_reg_fu_op, out_reg_cond_codes};

  // Recognised instruction table: match when (insn & mask) == pattern.
  logic [31:0] t_pat  [16];
  logic [31:0] t_mask [16];
  int          t_op   [16];
  bit          t_set  [16];
  bit          t_use  [16];
  bit          t_imm  [16];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic add_entry(input int i, input logic [31:0] pat, input logic [31:0] mask,
                           input int op, input bit s, input bit u, input bit im);
    t_pat[i] = pat; t_mask[i] = mask; t_op[i] = op;
    t_set[i] = s; t_use[i] = u; t_imm[i] = im;
  endtask

  task automatic init_table();
    add_entry(0,  32'h9100_0000, 32'hFFC0_0000, 0, 1'b0, 1'b0, 1'b1);
    add_entry(1,  32'hB100_0000, 32'hFFC0_0000, 0, 1'b1, 1'b0, 1'b1);
    add_entry(2,  32'hD100_0000, 32'hFFC0_0000, 1, 1'b0, 1'b0, 1'b1);
    add_entry(3,  32'hF100_0000, 32'hFFC0_0000, 1, 1'b1, 1'b0, 1'b1);
    add_entry(4,  32'h8B00_0000, 32'hFFE0_0000, 0, 1'b0, 1'b0, 1'b0);
    add_entry(5,  32'hAB00_0000, 32'hFFE0_0000, 0, 1'b1, 1'b0, 1'b0);
    add_entry(6,  32'hCB00_0000, 32'hFFE0_0000, 1, 1'b0, 1'b0, 1'b0);
    add_entry(7,  32'hEB00_0000, 32'hFFE0_0000, 1, 1'b1, 1'b0, 1'b0);
    add_entry(8,  32'h8A00_0000, 32'hFFE0_0000, 6, 1'b0, 1'b0, 1'b0);
    add_entry(9,  32'hAA00_0000, 32'hFFE0_0000, 7, 1'b0, 1'b0, 1'b0);
    add_entry(10, 32'hCA00_0000, 32'hFFE0_0000, 8, 1'b0, 1'b0, 1'b0);
    add_entry(11, 32'hEA00_0000, 32'hFFE0_0000, 6, 1'b1, 1'b0, 1'b0);
    add_entry(12, 32'h9A80_0000, 32'hFFE0_0C00, 2, 1'b0, 1'b1, 1'b0);
    add_entry(13, 32'h9A80_0400, 32'hFFE0_0C00, 3, 1'b0, 1'b1, 1'b0);
    add_entry(14, 32'hDA80_0000, 32'hFFE0_0C00, 4, 1'b0, 1'b1, 1'b0);
    add_entry(15, 32'hDA80_0400, 32'hFFE0_0C00, 5, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [63:0] pack(input bit done, input bit s, input bit u, input bit im,
                                       input int imm, input int s1, input int s2, input int d,
                                       input int op, input int cc);
    logic [63:0] r;
    r = 64'd0;
    r[40] = done; r[39] = s; r[38] = u; r[37] = im;
    r[36:25] = 12'(imm); r[24:20] = 5'(s1); r[19:15] = 5'(s2);
    r[14:10] = 5'(d); r[9:8] = 2'b00; r[7:4] = 4'(op); r[3:0] = 4'(cc);
    return r;
  endfunction

  function automatic logic [63:0] ref_decode(input logic [31:0] insn);
    int w;
    w = int'(insn);
    for (int i = 0; i < 16; i++) begin
      if ((insn & t_mask[i]) == t_pat[i]) begin
        return pack(1'b1, t_set[i], t_use[i], t_imm[i],
                    t_imm[i] ? ((w >> 10) & 4095) : 0,
                    (w >> 5) & 31,
                    t_imm[i] ? 0 : ((w >> 16) & 31),
                    w & 31, t_op[i],
                    t_use[i] ? ((w >> 12) & 15) : 0);
      end
    end
    return 64'd0;
  endfunction

  // One cycle: drive inputs, advance the model at the edge, compare just after.
  task automatic step(input logic [31:0] insn, input logic fd, input logic st);
    in_fetch_insnbits = insn;
    in_fetch_done = fd;
    in_stall = st;
    @(posedge in_clk);
    if (!st) exp_bundle = fd ? ref_decode(insn) : 64'd0;
    #1;
    check_val("bundle", obs, exp_bundle);
  endtask

  task automatic reset_pulse();
    #2;
    in_rst = 1'b1;
    #1;
    check_val("async_rst", obs, 64'd0);
    exp_bundle = 64'd0;
    #1;
    in_rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_insn();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 23);
    w = $urandom;
    if (k < 16) return t_pat[k] | (w & ~t_mask[k]);
    if (k < 19) return (t_pat[k - 16] | (w & ~t_mask[k - 16])) ^ (32'd1 << $urandom_range(21, 31));
    if (k == 19) return 32'hD503_201F;
    return w;
  endfunction

  initial begin
    init_table();
    exp_bundle = 64'd0;
    in_rst = 1'b1;
    in_stall = 1'b0;
    in_fetch_done = 1'b0;
    in_fetch_insnbits = 32'd0;
    #12;
    check_val("reset_state", obs, 64'd0);
    in_rst = 1'b0;
    step(32'd0, 1'b0, 1'b0);
    check_val("idle_done", 64'(out_reg_done), 64'd0);

    step(32'h913F_FC21, 1'b1, 1'b0);
    check_val("addi_done", 64'(out_reg_done), 64'd1);
    check_val("addi_use_imm", 64'(out_reg_use_imm), 64'd1);
    check_val("addi_imm", 64'(out_reg_imm), 64'hFFF);
    check_val("addi_src1", 64'(out_reg_src1), 64'd1);
    check_val("addi_dst", 64'(out_reg_dst), 64'd1);
    check_val("addi_op", 64'(out_reg_fu_op), 64'd0);
    check_val("addi_set", 64'(out_reg_set_nzcv), 64'd0);
    check_val("addi_uses", 64'(out_reg_instr_uses_nzcv), 64'd0);

    for (int i = 0; i < 3; i++) begin
      step(32'hAB01_0022, 1'b1, 1'b1);
      check_val("stall_hold_imm", 64'(out_reg_imm), 64'hFFF);
    end
    step(32'hAB01_0022, 1'b1, 1'b0);
    check_val("adds_src1", 64'(out_reg_src1), 64'd1);
    check_val("adds_src2", 64'(out_reg_src2), 64'd1);
    check_val("adds_dst", 64'(out_reg_dst), 64'd2);
    check_val("adds_set", 64'(out_reg_set_nzcv), 64'd1);
    check_val("adds_use_imm", 64'(out_reg_use_imm), 64'd0);

    step(32'hEB01_0063, 1'b1, 1'b0);
    check_val("subs_op", 64'(out_reg_fu_op), 64'd1);
    check_val("subs_dst", 64'(out_reg_dst), 64'd3);

    step(32'hDA81_0067, 1'b1, 1'b0);
    check_val("csinv_op", 64'(out_reg_fu_op), 64'd4);
    check_val("csinv_dst", 64'(out_reg_dst), 64'd7);
    check_val("csinv_uses", 64'(out_reg_instr_uses_nzcv), 64'd1);
    check_val("csinv_cond", 64'(out_reg_cond_codes), 64'd0);

    step(32'hD503_201F, 1'b1, 1'b0);
    check_val("nop_done", 64'(out_reg_done), 64'd0);
    step(32'h9140_0421, 1'b1, 1'b0);
    check_val("addi_sh1_done", 64'(out_reg_done), 64'd0);
    step(32'h9A81_B0A4, 1'b1, 1'b0);
    check_val("csel_cond", 64'(out_reg_cond_codes), 64'hB);
    reset_pulse();

    for (int n = 0; n < 2000; n++) begin
      step(rand_insn(), 1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 2));
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
